// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//   Round-sequencing controller for an iterative AES datapath. It supports
//   AES-128, AES-192 and AES-256 (10, 12 or 14 rounds), and the key length is
//   chosen per operation. Each middle and last round takes CYCLES_PER_ROUND
//   datapath cycles. The block drives the state-register input mux, a
//   one-cycle key-expansion request per round, and the round-key index.
//
//   Optional build macro: AES_ROUND_CTRL_DECRYPT_EN
//     When defined, the block has an extra input `decrypt`, latched with start.
//     With decrypt=1 the round keys are issued in reverse order
//     (key_idx = nr - round_idx). When the macro is undefined there is no
//     decrypt port and key_idx follows round_idx.
//
//   Ports
//     clk, reset_n : clock; asynchronous active-low reset
//     start        : begin an operation (only sampled while ready)
//     key_len      : 00=128, 01=192, 10=256, 11=reserved (raises err)
//     decrypt      : (macro builds only) reverse key order, latched with start
//     ready        : idle, able to accept start
//     busy         : operation in progress (INIT/MID/LAST)
//     mux_sel      : 0=load plaintext path, 1=feedback path
//     req_key      : key-expansion request, exactly one cycle per round
//     key_idx      : round-key index for the current round, 0 when idle
//     last_round   : final round in progress (datapath skips MixColumns)
//     done         : one-cycle pulse after the final LAST cycle
//     err          : one-cycle pulse after a start with reserved key_len
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int CYCLES_PER_ROUND = 3,
   parameter int KEY_REQ_CYCLE    = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [1:0] key_len,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
   input  logic       decrypt,
`endif
   output logic       ready,
   output logic       busy,
   output logic       mux_sel,
   output logic       req_key,
   output logic [3:0] key_idx,
   output logic       last_round,
   output logic       done,
   output logic       err
);

   localparam int CW = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
   localparam logic [CW-1:0] CYC_LOAD = CW'(CYCLES_PER_ROUND - 1);
   localparam logic [CW-1:0] KEY_CYC  = CW'(KEY_REQ_CYCLE);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_MID, S_LAST} state_t;

   state_t          state, state_nx;
   logic [3:0]      round_idx, round_nx;
   logic [CW-1:0]   cyc, cyc_nx;
   logic [3:0]      nr, nr_nx;
   logic            done_nx, err_nx;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
   logic            dec_q, dec_nx;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         round_idx <= 4'd0;
         cyc       <= '0;
         nr        <= 4'd10;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
         dec_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         round_idx <= round_nx;
         cyc       <= cyc_nx;
         nr        <= nr_nx;
         done      <= done_nx;
         err       <= err_nx;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
         dec_q     <= dec_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      round_nx = round_idx;
      cyc_nx   = cyc;
      nr_nx    = nr;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      dec_nx   = dec_q;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               if (key_len == 2'b11) begin
                  err_nx = 1'b1;
               end else begin
                  // NR = 10 + 2*key_len for the three legal encodings
                  nr_nx    = 4'd10 + {1'b0, key_len, 1'b0};
                  round_nx = 4'd0;
                  state_nx = S_INIT;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
                  dec_nx   = decrypt;
`endif
               end
            end
         end
         S_INIT: begin
            state_nx = S_MID;
            round_nx = 4'd1;
            cyc_nx   = CYC_LOAD;
         end
         S_MID: begin
            if (cyc != '0) begin
               cyc_nx = cyc - CW'(1);
            end else begin
               cyc_nx   = CYC_LOAD;
               round_nx = round_idx + 4'd1;
               if (round_idx == nr - 4'd1) state_nx = S_LAST;
            end
         end
         S_LAST: begin
            if (cyc != '0) begin
               cyc_nx = cyc - CW'(1);
            end else begin
               state_nx = S_IDLE;
               round_nx = 4'd0;
               cyc_nx   = '0;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign ready      = (state == S_IDLE);
   assign busy       = !ready;
   assign mux_sel    = (state == S_MID) || (state == S_LAST);
   assign last_round = (state == S_LAST);
   // Each round passes through every cyc value exactly once, so this is one pulse per round
   assign req_key    = mux_sel && (cyc == KEY_CYC);

`ifdef AES_ROUND_CTRL_DECRYPT_EN
   assign key_idx = ready ? 4'd0 : (dec_q ? (nr - round_idx) : round_idx);
`else
   assign key_idx = ready ? 4'd0 : round_idx;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
   localparam int C = 3;
   localparam int K = 1;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [1:0] key_len;
   bit         dec_drv;
   logic       ready, busy, mux_sel, req_key, last_round, done, err;
   logic [3:0] key_idx;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
   wire        decrypt = dec_drv;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aes_round_ctrl #(.CYCLES_PER_ROUND(C), .KEY_REQ_CYCLE(K)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .key_len    (key_len),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      .decrypt    (decrypt),
`endif
      .ready      (ready),
      .busy       (busy),
      .mux_sel    (mux_sel),
      .req_key    (req_key),
      .key_idx    (key_idx),
      .last_round (last_round),
      .done       (done),
      .err        (err)
   );

   // {ready,busy,mux_sel,req_key,key_idx[3:0],last_round,done,err}
   wire [10:0] obs = {ready, busy, mux_sel, req_key, key_idx, last_round, done, err};

   function automatic bit dec_en();
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Reference timeline: t = cycle offset after start accepted.
   // t<0 idle; t=0 INIT; 1..nr*C round cycles; nr*C+1 done cycle.
   function automatic logic [10:0] exp_vec(int t, int nr, bit dec);
      int r, cy;
      logic [3:0] k;
      if (t < 0) return {1'b1, 10'd0};
      if (t == 0) begin
         k = dec ? 4'(nr) : 4'd0;
         return {1'b0, 1'b1, 1'b0, 1'b0, k, 1'b0, 1'b0, 1'b0};
      end
      if (t > nr * C) return {1'b1, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0};
      r  = (t - 1) / C + 1;
      cy = C - 1 - ((t - 1) % C);
      k  = dec ? 4'(nr - r) : 4'(r);
      return {1'b0, 1'b1, 1'b1, (cy == K), k, (r == nr), 1'b0, 1'b0};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; key_len = 2'b00; dec_drv = 1'b0;
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec(-1, 10, 0)) begin
         n_fail++; $display("FAIL reset_in: got %b exp %b", obs, exp_vec(-1, 10, 0));
      end
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_vec(-1, 10, 0)) begin
            n_fail++; $display("FAIL reset_out: got %b exp %b", obs, exp_vec(-1, 10, 0));
         end
      end
   endtask

   task automatic test_single_op(input string name, input logic [1:0] kl, input bit dec);
      int nr, pulses, lasts;
      bit de;
      nr = 10 + 2 * int'(kl); pulses = 0; lasts = 0; de = dec & dec_en();
      start = 1'b1; key_len = kl; dec_drv = dec;
      for (int t = 0; t <= nr * C + 1; t++) begin
         @(negedge clk);
         start = 1'b0;
         n_chk++;
         if (obs !== exp_vec(t, nr, de)) begin
            n_fail++; $display("FAIL %s t=%0d: got %b exp %b", name, t, obs, exp_vec(t, nr, de));
         end
         pulses += int'(req_key);
         lasts  += int'(last_round);
      end
      n_chk++;
      if (pulses != nr) begin
         n_fail++; $display("FAIL %s req_key_count: got %0d exp %0d", name, pulses, nr);
      end
      n_chk++;
      if (lasts != C) begin
         n_fail++; $display("FAIL %s last_round_cycles: got %0d exp %0d", name, lasts, C);
      end
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec(-1, nr, de)) begin
         n_fail++; $display("FAIL %s post_idle: got %b exp %b", name, obs, exp_vec(-1, nr, de));
      end
   endtask

   task automatic test_reserved();
      start = 1'b1; key_len = 2'b11;
      @(negedge clk);
      start = 1'b0; key_len = 2'b00;
      n_chk++;
      if (obs !== {1'b1, 9'd0, 1'b1}) begin
         n_fail++; $display("FAIL reserved_err: got %b exp %b", obs, {1'b1, 9'd0, 1'b1});
      end
      repeat (3) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_vec(-1, 10, 0)) begin
            n_fail++; $display("FAIL reserved_after: got %b exp %b", obs, exp_vec(-1, 10, 0));
         end
      end
   endtask

   // start held high throughout; key_len churns while busy; restart in done cycle
   task automatic test_back_to_back();
      start = 1'b1; key_len = 2'b00; dec_drv = 1'b0;
      for (int t = 0; t <= 10 * C + 1; t++) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_vec(t, 10, 0)) begin
            n_fail++; $display("FAIL b2b_op1 t=%0d: got %b exp %b", t, obs, exp_vec(t, 10, 0));
         end
         key_len = (t <= 10 * C) ? 2'($urandom_range(0, 3)) : 2'b01;
      end
      for (int t = 0; t <= 12 * C + 1; t++) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_vec(t, 12, 0)) begin
            n_fail++; $display("FAIL b2b_op2 t=%0d: got %b exp %b", t, obs, exp_vec(t, 12, 0));
         end
         key_len = 2'($urandom_range(0, 3));
         if (t >= 12 * C) start = 1'b0;
      end
      @(negedge clk);
      n_chk++;
      if (obs !== exp_vec(-1, 12, 0)) begin
         n_fail++; $display("FAIL b2b_idle: got %b exp %b", obs, exp_vec(-1, 12, 0));
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; key_len = 2'b01; dec_drv = 1'b0;
      for (int t = 0; t <= 14; t++) begin
         @(negedge clk);
         start = 1'b0;
         n_chk++;
         if (obs !== exp_vec(t, 12, 0)) begin
            n_fail++; $display("FAIL rstmid_pre t=%0d: got %b exp %b", t, obs, exp_vec(t, 12, 0));
         end
      end
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (obs !== exp_vec(-1, 12, 0)) begin
         n_fail++; $display("FAIL rstmid_async: got %b exp %b", obs, exp_vec(-1, 12, 0));
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         n_chk++;
         if (obs !== exp_vec(-1, 12, 0)) begin
            n_fail++; $display("FAIL rstmid_nodone: got %b exp %b", obs, exp_vec(-1, 12, 0));
         end
      end
   endtask

   task automatic test_random();
      int nr, gap;
      bit de;
      logic [1:0] kl;
      for (int op = 0; op < 25; op++) begin
         start = 1'b0;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_vec(-1, 10, 0)) begin
               n_fail++; $display("FAIL rand_gap op=%0d: got %b exp %b", op, obs, exp_vec(-1, 10, 0));
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            start = 1'b1; key_len = 2'b11;
            @(negedge clk);
            start = 1'b0;
            n_chk++;
            if (obs !== {1'b1, 9'd0, 1'b1}) begin
               n_fail++; $display("FAIL rand_err op=%0d: got %b exp %b", op, obs, {1'b1, 9'd0, 1'b1});
            end
         end
         kl = 2'($urandom_range(0, 2));
         dec_drv = 1'($urandom_range(0, 1));
         de = dec_drv & dec_en();
         nr = 10 + 2 * int'(kl);
         start = 1'b1; key_len = kl;
         for (int t = 0; t <= nr * C + 1; t++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_vec(t, nr, de)) begin
               n_fail++; $display("FAIL rand op=%0d nr=%0d t=%0d: got %b exp %b", op, nr, t, obs, exp_vec(t, nr, de));
            end
            if (t <= nr * C) begin
               start   = 1'($urandom_range(0, 1));
               key_len = 2'($urandom_range(0, 3));
               dec_drv = 1'($urandom_range(0, 1));
            end else begin
               start = 1'b0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_op("aes128", 2'b00, 1'b0);
      test_single_op("aes256", 2'b10, 1'b0);
      test_single_op("aes192", 2'b01, 1'b0);
      test_single_op("aes128_dec", 2'b00, 1'b1);
      test_reserved();
      test_back_to_back();
      test_reset_mid();
      test_single_op("restart", 2'b00, 1'b0);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
